// File: rtl/err_collect_if.sv
// ---------------------------------------------------------------------------
// err_collect_if
// Bundles the error-index input stream and the drained-index output stream
// of err_collect, together with its status outputs.
//
//   err_valid  [1:0]   code: 00 idle, 01 index valid, 10 clear, 11 finished
//   err_idx    [IDX_W] error index, meaningful with code 01
//   out_ready          downstream accepts out_idx
//   out_valid          out_idx holds a stored index
//   out_idx    [IDX_W] drained error index
//   out_last           out_idx is the final entry of the list
//   done               one-cycle pulse, list fully delivered
//   weight     [WGT_W] current entry count
//   overflow           sticky, an append was dropped (list full)
//   range_err          sticky, an index >= N_LEN was received
//
// master: the side that drives codes/indices and consumes the output.
// slave : the collector itself.
// ---------------------------------------------------------------------------
interface err_collect_if #(
    parameter int IDX_W = 13,
    parameter int MAX_W = 64
);
    localparam int WGT_W = $clog2(MAX_W + 1);

    logic [1:0]       err_valid;
    logic [IDX_W-1:0] err_idx;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             done;
    logic [WGT_W-1:0] weight;
    logic             overflow;
    logic             range_err;

    modport master (
        output err_valid, err_idx, out_ready,
        input  out_valid, out_idx, out_last, done, weight, overflow, range_err
    );

    modport slave (
        input  err_valid, err_idx, out_ready,
        output out_valid, out_idx, out_last, done, weight, overflow, range_err
    );
endinterface

// File: rtl/err_collect.sv
// ---------------------------------------------------------------------------
// err_collect
// Collects error locations produced by a syndrome/error generator into a
// list, then streams the list out over a valid/ready handshake.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous reset, active high, dominates all other inputs
//   bus   err_collect_if.slave (see the interface file for signal meanings)
//
// Behaviour summary:
//   COLLECT: code 01 appends an in-range index (or cancels it if already
//            present, when cancellation is built in); 10 empties the list;
//            the first cycle of an 11 run starts the drain (or pulses done
//            straight away for an empty list).
//   DRAIN  : entries 0..weight-1 are presented in order; the transfer of the
//            last one returns to COLLECT with an empty list and pulses done.
//
// Build option:
//   ERR_COLLECT_CANCEL_EN  when defined, a received index that is already in
//   the list removes it instead (GF(2) cancellation): the tail entry moves
//   into the freed slot. When undefined there is no search logic and every
//   in-range index is appended, duplicates included.
// ---------------------------------------------------------------------------
module err_collect #(
    parameter int MAX_W = 64,
    parameter int IDX_W = 13,
    parameter int N_LEN = 4900
) (
    input  logic         clk,
    input  logic         rst,
    err_collect_if.slave bus
);
    localparam int WGT_W = $clog2(MAX_W + 1);
    localparam int PTR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [1:0] CODE_IDX = 2'b01;
    localparam logic [1:0] CODE_CLR = 2'b10;
    localparam logic [1:0] CODE_FIN = 2'b11;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] entry_reg [0:MAX_W-1];
    logic [WGT_W-1:0] weight_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [1:0]       prev_code_reg;
    logic             out_valid_reg;
    logic [IDX_W-1:0] out_idx_reg;
    logic             out_last_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic             range_err_reg;

    logic             idx_in_range;
    logic             list_full;
    logic             finish_edge;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] next_rd_ptr;

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [IDX_W-1:0] wr_data;

    logic             hit_any;
    logic [PTR_W-1:0] hit_pos;

    assign idx_in_range = (32'(bus.err_idx) < 32'(N_LEN));
    assign list_full    = (weight_reg == WGT_W'(MAX_W));
    // Only the first cycle of an 11 run counts; the history register keeps
    // tracking in DRAIN as well so a held 11 cannot restart a drain.
    assign finish_edge  = (bus.err_valid == CODE_FIN) && (prev_code_reg != CODE_FIN);
    // weight can equal MAX_W, which truncates to 0 here; no write happens
    // in that case because the append is dropped.
    assign wr_ptr       = PTR_W'(weight_reg);
    assign tail_ptr     = PTR_W'(weight_reg - WGT_W'(1));
    assign next_rd_ptr  = rd_ptr_reg + PTR_W'(1);

`ifdef ERR_COLLECT_CANCEL_EN
    // Parallel compare of the incoming index against every live entry.
    logic [MAX_W-1:0] hit_vec;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_W; gi++) begin : g_match
            assign hit_vec[gi] = (WGT_W'(gi) < weight_reg) &&
                                 (entry_reg[gi] == bus.err_idx);
        end
    endgenerate

    // Entries are unique while cancellation is on, so at most one bit is
    // set; the priority loop just turns it into a position.
    always_comb begin
        hit_pos = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_pos = PTR_W'(i);
            end
        end
    end

    assign hit_any = |hit_vec;
`else
    assign hit_any = 1'b0;
    assign hit_pos = '0;
`endif

    // Single write port into the entry store: either an append at the end
    // or, on cancellation, the tail entry copied into the freed slot.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_ptr;
        wr_data = bus.err_idx;
        if (!rst && (state_reg == COLLECT) &&
            (bus.err_valid == CODE_IDX) && idx_in_range) begin
            if (hit_any) begin
                wr_en   = 1'b1;
                wr_addr = hit_pos;
                wr_data = entry_reg[tail_ptr];
            end else if (!list_full) begin
                wr_en   = 1'b1;
            end
        end
    end

    // Entry contents need no reset: weight alone defines which are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= COLLECT;
            weight_reg    <= '0;
            rd_ptr_reg    <= '0;
            prev_code_reg <= 2'b00;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            prev_code_reg <= bus.err_valid;
            done_reg      <= 1'b0;

            case (state_reg)
                COLLECT: begin
                    case (bus.err_valid)
                        CODE_IDX: begin
                            if (!idx_in_range) begin
                                range_err_reg <= 1'b1;
                            end else if (hit_any) begin
                                weight_reg <= weight_reg - WGT_W'(1);
                            end else if (list_full) begin
                                overflow_reg <= 1'b1;
                            end else begin
                                weight_reg <= weight_reg + WGT_W'(1);
                            end
                        end
                        CODE_CLR: begin
                            weight_reg <= '0;
                        end
                        CODE_FIN: begin
                            if (finish_edge) begin
                                if (weight_reg == '0) begin
                                    done_reg <= 1'b1;
                                end else begin
                                    // Registered read of entry 0 so out_idx
                                    // is valid on the first DRAIN cycle.
                                    state_reg     <= DRAIN;
                                    rd_ptr_reg    <= '0;
                                    out_valid_reg <= 1'b1;
                                    out_idx_reg   <= entry_reg[0];
                                    out_last_reg  <= (weight_reg == WGT_W'(1));
                                end
                            end
                        end
                        default: ;
                    endcase
                end

                DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= COLLECT;
                            weight_reg    <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            rd_ptr_reg    <= next_rd_ptr;
                            out_idx_reg   <= entry_reg[next_rd_ptr];
                            out_last_reg  <= (WGT_W'(next_rd_ptr) ==
                                              weight_reg - WGT_W'(1));
                        end
                    end
                end

                default: state_reg <= COLLECT;
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.done      = done_reg;
    assign bus.weight    = weight_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.range_err = range_err_reg;
endmodule

// File: tb/tb_err_collect.sv
// ---------------------------------------------------------------------------
// tb_err_collect
// Self-checking bench for err_collect. Expected list contents come from a
// queue model that applies the append / cancel / clear rules directly.
// Build with ERR_COLLECT_CANCEL_EN defined to check the cancelling variant.
// ---------------------------------------------------------------------------
module tb_err_collect;
    localparam int MAX_W = 64;
    localparam int IDX_W = 13;
    localparam int N_LEN = 4900;

`ifdef ERR_COLLECT_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic clk;
    logic rst;

    err_collect_if #(.IDX_W(IDX_W), .MAX_W(MAX_W)) bus ();

    err_collect #(
        .MAX_W (MAX_W),
        .IDX_W (IDX_W),
        .N_LEN (N_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    int model_q[$];
    bit m_ovf = 1'b0;
    bit m_rng = 1'b0;

    typedef struct {
        logic [1:0] code;
        int         idx;
        int         exp_w;
        bit         exp_rng;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.err_valid = 2'b00;
        bus.err_idx   = '0;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_rng = 1'b0;
    endtask

    function automatic void model_apply(input logic [1:0] code, input int idx);
        int k;
        if (code == 2'b01) begin
            if (idx >= N_LEN) begin
                m_rng = 1'b1;
            end else begin
                k = -1;
                if (CANCEL) begin
                    for (int i = 0; i < model_q.size(); i++)
                        if (model_q[i] == idx) k = i;
                end
                if (k >= 0) begin
                    model_q[k] = model_q[model_q.size() - 1];
                    void'(model_q.pop_back());
                end else if (model_q.size() == MAX_W) begin
                    m_ovf = 1'b1;
                end else begin
                    model_q.push_back(idx);
                end
            end
        end else if (code == 2'b10) begin
            model_q.delete();
        end
    endfunction

    // One COLLECT-phase cycle with a code, then check against the model.
    task automatic send(input logic [1:0] code, input int idx);
        bus.err_valid = code;
        bus.err_idx   = idx[IDX_W-1:0];
        step();
        model_apply(code, idx);
        check("weight", int'(bus.weight), model_q.size());
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("range_err", int'(bus.range_err), int'(m_rng));
        check("collect_out_valid", int'(bus.out_valid), 0);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1,1 then 1, 2: random
    function automatic bit ready_for(input int mode, input int c);
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c < 5) ? pat[c] : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Issue a finish code (held for the whole drain) and check the stream.
    task automatic finish_and_drain(input int mode);
        int  n_got;
        bit  rdy;
        bit  exp_last;
        bit  prev_stall;
        bit  finished;
        int  prev_idx;
        n_got      = 0;
        prev_stall = 1'b0;
        finished   = 1'b0;
        prev_idx   = 0;
        bus.err_valid = 2'b11;
        bus.out_ready = 1'b0;
        step();
        if (model_q.size() == 0) begin
            check("empty_done", int'(bus.done), 1);
            check("empty_valid", int'(bus.out_valid), 0);
            $display("finish on empty list: done=%0d", bus.done);
        end else begin
            for (int c = 0; c < 2000 && !finished; c++) begin
                check("drain_valid", int'(bus.out_valid), 1);
                if (prev_stall) check("hold_idx", int'(bus.out_idx), prev_idx);
                rdy = ready_for(mode, c);
                bus.out_ready = rdy;
                exp_last = (n_got == model_q.size() - 1);
                if (rdy) begin
                    check("out_idx", int'(bus.out_idx), model_q[n_got]);
                    check("out_last", int'(bus.out_last), int'(exp_last));
                    $display("xfer %0d idx=%0d last=%0d", n_got, bus.out_idx, bus.out_last);
                    n_got++;
                end
                prev_stall = !rdy;
                prev_idx   = int'(bus.out_idx);
                step();
                if (rdy && exp_last) finished = 1'b1;
            end
            check("drain_finished", int'(finished), 1);
            check("xfer_count", n_got, model_q.size());
            check("end_done", int'(bus.done), 1);
            check("end_valid", int'(bus.out_valid), 0);
            check("end_weight", int'(bus.weight), 0);
        end
        model_q.delete();
        bus.out_ready = 1'b0;
        // 11 still held: must not restart anything
        step();
        check("held_fin_done", int'(bus.done), 0);
        check("held_fin_valid", int'(bus.out_valid), 0);
        bus.err_valid = 2'b00;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers;
        int dones;
        int first_idx;
        int sel;
        int n;

        // Table: distinct indices only, so valid with or without cancellation
        tbl[0] = '{2'b01, 5,    1, 1'b0};
        tbl[1] = '{2'b01, 17,   2, 1'b0};
        tbl[2] = '{2'b01, 4899, 3, 1'b0};
        tbl[3] = '{2'b01, 4900, 3, 1'b1};
        tbl[4] = '{2'b00, 123,  3, 1'b1};
        tbl[5] = '{2'b10, 0,    0, 1'b1};
        tbl[6] = '{2'b01, 0,    1, 1'b1};
        tbl[7] = '{2'b01, 8191, 1, 1'b1};

        bus.err_valid = 2'b00;
        bus.err_idx   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_weight", int'(bus.weight), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_idx", int'(bus.out_idx), 0);
        check("rst_last", int'(bus.out_last), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ovf", int'(bus.overflow), 0);
        check("rst_rng", int'(bus.range_err), 0);

        for (int i = 0; i < 8; i++) begin
            bus.err_valid = tbl[i].code;
            bus.err_idx   = tbl[i].idx[IDX_W-1:0];
            step();
            $display("vec %0d code=%0d idx=%0d weight=%0d", i, tbl[i].code, tbl[i].idx, bus.weight);
            check("tbl_weight", int'(bus.weight), tbl[i].exp_w);
            check("tbl_range", int'(bus.range_err), int'(tbl[i].exp_rng));
            check("tbl_valid", int'(bus.out_valid), 0);
        end

        // Basic three-entry drain
        do_reset();
        send(2'b01, 5);
        send(2'b01, 17);
        send(2'b01, 4899);
        check("basic_weight", int'(bus.weight), 3);
        finish_and_drain(0);

        // Duplicate handling
        do_reset();
        send(2'b01, 5);
        send(2'b01, 17);
        send(2'b01, 42);
        send(2'b01, 5);
        check("dup_weight", int'(bus.weight), CANCEL ? 2 : 4);
        bus.err_valid = 2'b11;
        step();
        check("dup_first", int'(bus.out_idx), CANCEL ? 42 : 5);
        bus.err_valid = 2'b00;
        do_reset();

        // Clear then held finish: one drain, one done
        send(2'b01, 10);
        send(2'b01, 20);
        send(2'b10, 0);
        send(2'b01, 30);
        xfers = 0;
        dones = 0;
        first_idx = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.err_valid = (c < 5) ? 2'b11 : 2'b00;
            if (bus.out_valid && bus.out_ready) begin
                if (xfers == 0) first_idx = int'(bus.out_idx);
                xfers++;
            end
            step();
            if (bus.done) dones++;
        end
        $display("held finish: xfers=%0d dones=%0d", xfers, dones);
        check("held_xfers", xfers, 1);
        check("held_idx", first_idx, 30);
        check("held_dones", dones, 1);
        model_q.delete();
        bus.out_ready = 1'b0;

        // Overflow and range error
        do_reset();
        for (int i = 0; i <= MAX_W; i++) send(2'b01, i * 7);
        check("ovf_weight", int'(bus.weight), MAX_W);
        check("ovf_flag", int'(bus.overflow), 1);
        send(2'b01, 4900);
        check("rng_flag", int'(bus.range_err), 1);
        check("rng_weight", int'(bus.weight), MAX_W);
        finish_and_drain(2);
        check("ovf_sticky", int'(bus.overflow), 1);

        // Stalled drain then reset mid-drain
        do_reset();
        send(2'b01, 100);
        send(2'b01, 200);
        send(2'b01, 300);
        finish_and_drain(1);
        send(2'b01, 1);
        send(2'b01, 2);
        send(2'b01, 3);
        bus.err_valid = 2'b11;
        step();
        bus.err_valid = 2'b00;
        bus.out_ready = 1'b1;
        step();
        check("middrain_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_rng = 1'b0;
        bus.out_ready = 1'b0;
        check("rst_drain_valid", int'(bus.out_valid), 0);
        check("rst_drain_weight", int'(bus.weight), 0);
        step();
        check("post_rst_valid", int'(bus.out_valid), 0);

        // Randomized collect/drain rounds against the model
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 90);
            for (int c = 0; c < n; c++) begin
                sel = $urandom_range(0, 19);
                if (sel < 15)      send(2'b01, $urandom_range(0, 40));
                else if (sel < 16) send(2'b01, $urandom_range(N_LEN, 8191));
                else if (sel < 17) send(2'b10, $urandom_range(0, 8191));
                else               send(2'b00, $urandom_range(0, 8191));
            end
            finish_and_drain(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
